// File: rtl/traffic_input_conditioner.sv
// Conditions five asynchronous traffic/parking inputs: synchronize, debounce, then derive
// the presence level, a latched pedestrian request, a hold-extended emergency level and entry/exit pulses.
module traffic_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EMERG_HOLD      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic car_sensor_raw,
    input  logic ped_button_raw,
    input  logic emergency_raw,
    input  logic car_enter_raw,
    input  logic car_exit_raw,
    input  logic ped_ack,
    output logic car_sensor,
    output logic pedestrian_req,
    output logic emergency,
    output logic car_enter,
    output logic car_exit
);

    localparam int NCH    = 5;
    localparam int CH_CAR = 0;
    localparam int CH_PED = 1;
    localparam int CH_EMG = 2;
    localparam int CH_ENT = 3;
    localparam int CH_EXT = 4;

    localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LOAD = 8'(EMERG_HOLD);

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] r_sync1;
    logic [NCH-1:0] r_sync2;
    logic [NCH-1:0] r_lvl;
    logic [NCH-1:1] r_lvl_d;
    logic [7:0]     r_cnt [NCH];
    logic [7:0]     r_hold;
    logic           r_exit_pend;

    logic w_ped_rise;
    logic w_ent_rise;
    logic w_ext_rise;
    logic w_emg_fall;

    assign w_raw = {car_exit_raw, car_enter_raw, emergency_raw, ped_button_raw, car_sensor_raw};

    assign w_ped_rise = r_lvl[CH_PED] & ~r_lvl_d[CH_PED];
    assign w_ent_rise = r_lvl[CH_ENT] & ~r_lvl_d[CH_ENT];
    assign w_ext_rise = r_lvl[CH_EXT] & ~r_lvl_d[CH_EXT];
    assign w_emg_fall = ~r_lvl[CH_EMG] & r_lvl_d[CH_EMG];

    // The level register itself is a flop, so presence needs no extra stage.
    assign car_sensor = r_lvl[CH_CAR];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl[NCH-1:1];
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_lvl[i] <= ~r_lvl[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            car_enter      <= 1'b0;
            car_exit       <= 1'b0;
            r_exit_pend    <= 1'b0;
            pedestrian_req <= 1'b0;
            emergency      <= 1'b0;
            r_hold         <= '0;
        end else begin
            // Entry has priority; a coincident exit is deferred by one cycle.
            car_enter <= w_ent_rise;
            if (w_ent_rise) begin
                car_exit    <= 1'b0;
                r_exit_pend <= r_exit_pend | w_ext_rise;
            end else begin
                car_exit    <= r_exit_pend | w_ext_rise;
                r_exit_pend <= 1'b0;
            end

            if (ped_ack) begin
                pedestrian_req <= 1'b0;
            end else if (w_ped_rise) begin
                pedestrian_req <= 1'b1;
            end

            if (r_lvl[CH_EMG]) begin
                emergency <= 1'b1;
                r_hold    <= '0;
            end else if (w_emg_fall) begin
                emergency <= 1'b1;
                r_hold    <= HOLD_LOAD;
            end else if (r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
                if (r_hold == 8'd1) begin
                    emergency <= 1'b0;
                end
            end else begin
                emergency <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Self-checking bench for traffic_input_conditioner: directed edge-count scenarios followed by
// randomized inputs, all compared every cycle against a window-based behavioural model.
module tb_traffic_input_conditioner;

    localparam int D = 4;
    localparam int H = 8;

    logic clk = 1'b0;
    logic reset;
    logic car_sensor_raw, ped_button_raw, emergency_raw, car_enter_raw, car_exit_raw;
    logic ped_ack;
    logic car_sensor, pedestrian_req, emergency, car_enter, car_exit;

    int errors = 0;
    int checks = 0;

    traffic_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .EMERG_HOLD(H)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .car_sensor_raw(car_sensor_raw),
        .ped_button_raw(ped_button_raw),
        .emergency_raw (emergency_raw),
        .car_enter_raw (car_enter_raw),
        .car_exit_raw  (car_exit_raw),
        .ped_ack       (ped_ack),
        .car_sensor    (car_sensor),
        .pedestrian_req(pedestrian_req),
        .emergency     (emergency),
        .car_enter     (car_enter),
        .car_exit      (car_exit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: channel order car, ped, emergency, enter, exit.
    bit m_p1[5];
    bit m_p2[5];
    bit m_L[5];
    bit m_rise_prev[5];
    bit m_hist[5][$];
    int m_exit_due;
    int m_last_fall;
    int m_n;
    bit e_car, e_ped, e_em, e_enter, e_exit;

    function automatic bit get_raw(input int c);
        case (c)
            0:       return car_sensor_raw;
            1:       return ped_button_raw;
            2:       return emergency_raw;
            3:       return car_enter_raw;
            default: return car_exit_raw;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 5; c++) begin
            m_p1[c] = 0;
            m_p2[c] = 0;
            m_L[c] = 0;
            m_rise_prev[c] = 0;
            m_hist[c].delete();
        end
        m_exit_due  = 0;
        m_last_fall = -1000;
        e_car = 0; e_ped = 0; e_em = 0; e_enter = 0; e_exit = 0;
    endtask

    // A level flips once the last D synchronized samples all disagree with it.
    task automatic model_step();
        bit s;
        bit old;
        bit all_diff;
        m_n++;
        e_enter = m_rise_prev[3];
        m_exit_due += int'(m_rise_prev[4]);
        if (e_enter) begin
            e_exit = 0;
        end else if (m_exit_due > 0) begin
            e_exit = 1;
            m_exit_due--;
        end else begin
            e_exit = 0;
        end
        e_ped = ped_ack ? 1'b0 : (e_ped | m_rise_prev[1]);
        e_em  = m_L[2] || ((m_n - m_last_fall) <= H);
        for (int c = 0; c < 5; c++) begin
            s = m_p2[c];
            m_p2[c] = m_p1[c];
            m_p1[c] = get_raw(c);
            m_hist[c].push_back(s);
            if (m_hist[c].size() > D) void'(m_hist[c].pop_front());
            old = m_L[c];
            all_diff = (m_hist[c].size() == D);
            foreach (m_hist[c][k]) if (m_hist[c][k] == old) all_diff = 0;
            if (all_diff) m_L[c] = ~old;
            m_rise_prev[c] = m_L[c] & ~old;
            if (c == 2 && old && !m_L[c]) m_last_fall = m_n;
        end
        e_car = m_L[0];
    endtask

    task automatic compare_all();
        check("car_sensor", car_sensor, e_car);
        check("pedestrian_req", pedestrian_req, e_ped);
        check("emergency", emergency, e_em);
        check("car_enter", car_enter, e_enter);
        check("car_exit", car_exit, e_exit);
        check("enter_exit_exclusive", car_enter & car_exit, 0);
    endtask

    // One clock edge: advance the model with pre-edge inputs, then compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_car_sensor"}, car_sensor, 0);
        check({tag, "_ped_req"}, pedestrian_req, 0);
        check({tag, "_emergency"}, emergency, 0);
        check({tag, "_car_enter"}, car_enter, 0);
        check({tag, "_car_exit"}, car_exit, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, released just after the following edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int rem[5];
    bit val[5];

    initial begin
        reset = 1'b1;
        car_sensor_raw = 0; ped_button_raw = 0; emergency_raw = 0;
        car_enter_raw = 0; car_exit_raw = 0; ped_ack = 0;
        m_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset_state");
        reset = 1'b0;
        repeat (5) tick();

        // Presence: accepted at edge 6, a 3-cycle glitch is ignored.
        car_sensor_raw = 1;
        repeat (5) tick();
        check("car_edge5", car_sensor, 0);
        tick();
        check("car_edge6", car_sensor, 1);
        car_sensor_raw = 0;
        repeat (10) tick();
        car_sensor_raw = 1;
        repeat (3) tick();
        car_sensor_raw = 0;
        repeat (10) begin
            tick();
            check("car_glitch", car_sensor, 0);
        end

        // Simultaneous entry and exit.
        car_enter_raw = 1; car_exit_raw = 1;
        repeat (6) tick();
        check("enter_edge6", car_enter, 0);
        tick();
        check("enter_edge7", car_enter, 1);
        check("exit_edge7", car_exit, 0);
        tick();
        check("enter_edge8", car_enter, 0);
        check("exit_edge8", car_exit, 1);
        tick();
        check("exit_edge9", car_exit, 0);

        // Pedestrian request latching, repeat press, acknowledge.
        ped_button_raw = 1;
        repeat (6) tick();
        check("ped_edge6", pedestrian_req, 0);
        tick();
        check("ped_edge7", pedestrian_req, 1);
        repeat (13) tick();
        ped_button_raw = 0;
        repeat (8) tick();
        check("ped_held_after_release", pedestrian_req, 1);
        ped_button_raw = 1;
        repeat (8) tick();
        ped_button_raw = 0;
        repeat (8) tick();
        check("ped_second_press", pedestrian_req, 1);
        ped_ack = 1;
        tick();
        check("ped_ack_clear", pedestrian_req, 0);
        ped_ack = 0;
        tick();

        // Press during an active crossing: clear wins over the due set.
        ped_button_raw = 1; ped_ack = 1;
        repeat (8) tick();
        check("ped_ack_wins", pedestrian_req, 0);
        ped_ack = 0;
        repeat (3) tick();
        ped_button_raw = 0;
        repeat (6) tick();
        check("ped_press_discarded", pedestrian_req, 0);

        // Emergency rise and hold-extended fall.
        car_enter_raw = 0; car_exit_raw = 0;
        emergency_raw = 1;
        repeat (6) tick();
        check("em_edge6", emergency, 0);
        tick();
        check("em_edge7", emergency, 1);
        repeat (3) tick();
        emergency_raw = 0;
        repeat (14) tick();
        check("em_edge24_hold", emergency, 1);
        tick();
        check("em_edge25_fall", emergency, 0);
        repeat (5) tick();

        // Re-press during the hold: no low gap.
        emergency_raw = 1;
        repeat (10) tick();
        emergency_raw = 0;
        for (int e = 11; e <= 30; e++) begin
            if (e == 15) emergency_raw = 1;
            tick();
            check("em_no_gap", emergency, 1);
        end

        // Reset mid-hold and mid-debounce, then inputs held high after release.
        emergency_raw = 0;
        repeat (7) tick();
        car_enter_raw = 1; car_exit_raw = 1;
        repeat (3) tick();
        check("em_in_hold_before_rst", emergency, 1);
        do_reset();
        repeat (6) tick();
        check("rst_enter_edge6", car_enter, 0);
        tick();
        check("rst_enter_edge7", car_enter, 1);
        tick();
        check("rst_enter_edge8", car_enter, 0);
        check("rst_exit_edge8", car_exit, 1);
        tick();
        check("rst_exit_edge9", car_exit, 0);

        // Randomized phase with a mix of glitches, stable levels, acks and resets.
        for (int c = 0; c < 5; c++) begin
            rem[c] = 0;
            val[c] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 5; c++) begin
                if (rem[c] == 0) begin
                    val[c] = 1'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 14));
                end
                rem[c]--;
            end
            car_sensor_raw = val[0];
            ped_button_raw = val[1];
            emergency_raw  = val[2];
            car_enter_raw  = val[3];
            car_exit_raw   = val[4];
            ped_ack = ($urandom_range(0, 15) == 0);
            tick();
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
